// File: rtl/codec_pkg.sv
// Shared definitions for the WM8731 bring-up slice: register addresses,
// control-word packing, sequencer states and the codec's I2C address.
package codec_pkg;

  localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;

  localparam logic [6:0] R0  = 7'd0;
  localparam logic [6:0] R1  = 7'd1;
  localparam logic [6:0] R4  = 7'd4;
  localparam logic [6:0] R5  = 7'd5;
  localparam logic [6:0] R6  = 7'd6;
  localparam logic [6:0] R7  = 7'd7;
  localparam logic [6:0] R8  = 7'd8;
  localparam logic [6:0] R9  = 7'd9;
  localparam logic [6:0] R15 = 7'd15;

  typedef logic [15:0] cfg_word_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    POWER_WAIT = 3'd1,
    ISSUE      = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4,
    DONE       = 3'd5,
    ERROR      = 3'd6
  } seq_state_t;

  // WM8731 control words carry a 7-bit register address above 9 data bits
  function automatic cfg_word_t pack_cfg(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/codec_config_sequencer_if.sv
// Command channel between the config sequencer and the I2C master.
interface codec_config_sequencer_if;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [6:0]            cmd_dev_addr;
  codec_pkg::cfg_word_t  cmd_word;
  logic                  cmd_done;
  logic                  cmd_ack_err;

  modport master (
    output cmd_valid, cmd_dev_addr, cmd_word,
    input  cmd_ready, cmd_done, cmd_ack_err
  );

  modport slave (
    input  cmd_valid, cmd_dev_addr, cmd_word,
    output cmd_ready, cmd_done, cmd_ack_err
  );
endinterface

// File: rtl/codec_init_rom.sv
// WM8731 init table: index -> packed control word; unused indices read as zero.
module codec_init_rom
  import codec_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] index,
  output cfg_word_t        word
);

  // Table order matters: reset first, activate last once the format is set
  always_comb begin
    word = 16'h0000;
    case (index)
      IDX_W'(0): word = pack_cfg(R15, 9'h000);
      IDX_W'(1): word = pack_cfg(R6,  9'h010);
      IDX_W'(2): word = pack_cfg(R0,  9'h017);
      IDX_W'(3): word = pack_cfg(R1,  9'h017);
      IDX_W'(4): word = pack_cfg(R4,  9'h012);
      IDX_W'(5): word = pack_cfg(R5,  9'h000);
      IDX_W'(6): word = pack_cfg(R7,  9'h04A);
      IDX_W'(7): word = pack_cfg(R8,  9'h000);
      IDX_W'(8): word = pack_cfg(R9,  9'h001);
      default:   word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_config_sequencer.sv
// Post-reset WM8731 bring-up: power-up delay, then the init table written over
// the command port with NACK retries; i2s is released once every entry is ACKed.
module codec_config_sequencer
  import codec_pkg::*;
#(
  parameter int         NUM_REGS        = 9,
  parameter int         POWER_UP_CYCLES = 50000,
  parameter int         GAP_CYCLES      = 100,
  parameter int         MAX_RETRY       = 3,
  parameter logic [6:0] DEV_ADDR        = CODEC_I2C_ADDR,
  parameter bit         AUTO_START      = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  codec_config_sequencer_if.master  cmd,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [3:0]                o_err_index,
  output logic                      o_i2s_enable
);

  localparam int IDX_W   = $clog2(NUM_REGS + 1);
  localparam int DLY_MAX = (POWER_UP_CYCLES > GAP_CYCLES) ? POWER_UP_CYCLES : GAP_CYCLES;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DLY_W-1:0]   PU_LAST   = DLY_W'(POWER_UP_CYCLES - 1);
  localparam logic [DLY_W-1:0]   GAP_LAST  = DLY_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  seq_state_t         state_r, state_s;
  logic [IDX_W-1:0]   index_r, index_s;
  logic [RETRY_W-1:0] retry_r, retry_s;
  logic [DLY_W-1:0]   dly_r, dly_s;
  cfg_word_t          rom_word_s;

  logic       cmd_valid_r;
  cfg_word_t  cmd_word_r;
  logic       busy_r;
  logic       done_r;
  logic       error_r;
  logic [3:0] err_index_r;

  // Lookup on the next index so the word register lines up with ISSUE entry
  codec_init_rom #(.IDX_W(IDX_W)) u_rom (
    .index (index_s),
    .word  (rom_word_s)
  );

  // Next-state, counter and index logic
  always_comb begin
    state_s = state_r;
    index_s = index_r;
    retry_s = retry_r;
    dly_s   = dly_r;
    case (state_r)
      IDLE: begin
        if (AUTO_START || i_start) begin
          state_s = POWER_WAIT;
          dly_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      POWER_WAIT: begin
        if (dly_r == PU_LAST) begin
          state_s = ISSUE;
          index_s = '0;
          retry_s = '0;
          dly_s   = '0;
        end else begin
          dly_s = dly_r + DLY_W'(1);
        end
      end
      ISSUE: begin
        if (cmd.cmd_ready) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (!cmd.cmd_done) begin
          state_s = WAIT_DONE;
        end else if (!cmd.cmd_ack_err) begin
          retry_s = '0;
          index_s = index_r + IDX_W'(1);
          dly_s   = '0;
          state_s = (index_r == IDX_LAST) ? DONE : GAP;
        end else if (retry_r < RETRY_MAX) begin
          retry_s = retry_r + RETRY_W'(1);
          dly_s   = '0;
          state_s = GAP;
        end else begin
          state_s = ERROR;
        end
      end
      GAP: begin
        if (dly_r == GAP_LAST) begin
          state_s = ISSUE;
          dly_s   = '0;
        end else begin
          dly_s = dly_r + DLY_W'(1);
        end
      end
      DONE, ERROR: begin
        // Codec is already powered, so a restart skips the power-up wait
        if (i_start) begin
          state_s = ISSUE;
          index_s = '0;
          retry_s = '0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      index_r     <= '0;
      retry_r     <= '0;
      dly_r       <= '0;
      cmd_valid_r <= 1'b0;
      cmd_word_r  <= 16'h0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      err_index_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      index_r     <= index_s;
      retry_r     <= retry_s;
      dly_r       <= dly_s;
      cmd_valid_r <= (state_s == ISSUE);
      if (state_s == ISSUE) begin
        cmd_word_r <= rom_word_s;
      end
      busy_r      <= !(state_s inside {IDLE, DONE, ERROR});
      done_r      <= (state_s == DONE);
      error_r     <= (state_s == ERROR);
      err_index_r <= (state_s == ERROR) ? 4'(index_s) : 4'd0;
    end
  end

  assign cmd.cmd_valid    = cmd_valid_r;
  assign cmd.cmd_word     = cmd_word_r;
  assign cmd.cmd_dev_addr = DEV_ADDR;
  assign o_busy           = busy_r;
  assign o_done           = done_r;
  assign o_error          = error_r;
  assign o_err_index      = err_index_r;
  assign o_i2s_enable     = done_r;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Scoreboard bench: expected command words are queued by the stimulus and
// popped by a monitor on every handshake; a responder models the I2C master.
module tb_codec_config_sequencer;

  localparam int NREG  = 9;
  localparam int STALL = 10;
  localparam logic [15:0] EXP_WORD [NREG] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217,
                                             16'h0812, 16'h0A00, 16'h0E4A, 16'h1000, 16'h1201};

  logic clk, reset_n, start, b_start;
  logic o_busy, o_done, o_error, o_i2s_enable;
  logic [3:0] o_err_index;
  logic b_busy, b_done, b_error, b_i2s;
  logic [3:0] b_err_index;

  codec_config_sequencer_if cmd_if ();
  codec_config_sequencer_if cmd_b ();

  codec_config_sequencer #(.NUM_REGS(NREG), .POWER_UP_CYCLES(20), .GAP_CYCLES(4),
                           .MAX_RETRY(3), .DEV_ADDR(7'h1A), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start), .cmd(cmd_if),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_err_index(o_err_index), .o_i2s_enable(o_i2s_enable));

  codec_config_sequencer #(.NUM_REGS(NREG), .POWER_UP_CYCLES(20), .GAP_CYCLES(4),
                           .MAX_RETRY(3), .DEV_ADDR(7'h1A), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(b_start), .cmd(cmd_b),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_error),
    .o_err_index(b_err_index), .o_i2s_enable(b_i2s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, done_cyc = 0, gap_seq = 0, accept_cnt = 0, epoch = 0, b_valid_cnt = 0;
  int nack_plan [NREG];
  bit stall_req = 1'b0, stray_req = 1'b0;
  logic [15:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cmd_b.cmd_valid) b_valid_cnt <= b_valid_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int word_index(input logic [15:0] w);
    for (int i = 0; i < NREG; i++) if (EXP_WORD[i] == w) return i;
    return -1;
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(EXP_WORD[i]);
  endtask

  // I2C master model: ready/stall control, done pulse 3 clks after accept
  initial begin : responder
    int idx, att, last_idx, my_epoch, stall_cnt;
    bit nack, last_nack, stray_used;
    logic [15:0] stall_word;
    cmd_if.cmd_ready = 1'b1; cmd_if.cmd_done = 1'b0; cmd_if.cmd_ack_err = 1'b0;
    att = 0; last_idx = -1; last_nack = 1'b0; stall_cnt = 0; stray_used = 1'b0;
    stall_word = 16'h0000;
    forever begin
      @(negedge clk);
      cmd_if.cmd_ready = !(stall_req && stall_cnt < STALL);
      if (stall_req && stall_cnt > 0 && stall_cnt < STALL) begin
        check("stall_valid", cmd_if.cmd_valid, 1);
        check("stall_word", cmd_if.cmd_word, stall_word);
        stall_cnt++;
      end else if (stall_req && stall_cnt == 0 && cmd_if.cmd_valid) begin
        stall_word = cmd_if.cmd_word;
        stall_cnt = 1;
      end else if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        idx = word_index(cmd_if.cmd_word);
        att = (idx == last_idx && last_nack) ? att + 1 : 1;
        nack = (idx >= 0) && (att <= nack_plan[idx]);
        last_idx = idx; last_nack = nack; my_epoch = epoch;
        repeat (3) @(negedge clk);
        if (my_epoch == epoch) begin
          if (!nack && idx == NREG - 1) begin
            check("done_before_last", o_done, 0);
            check("busy_before_last", o_busy, 1);
          end
          if ((!nack && idx != NREG - 1) || (nack && att <= 3)) begin
            done_cyc = cyc + 1;
            gap_seq++;
          end
          cmd_if.cmd_done = 1'b1; cmd_if.cmd_ack_err = nack;
          @(negedge clk);
          cmd_if.cmd_done = 1'b0; cmd_if.cmd_ack_err = 1'b0;
          if (!nack && idx == NREG - 1) begin
            check("done_after_last", o_done, 1);
            check("i2s_after_last", o_i2s_enable, 1);
            check("busy_after_last", o_busy, 0);
          end
          if (stray_req && !stray_used && !nack && idx != NREG - 1) begin
            stray_used = 1'b1;
            @(negedge clk);
            cmd_if.cmd_done = 1'b1; cmd_if.cmd_ack_err = 1'b1;
            @(negedge clk);
            cmd_if.cmd_done = 1'b0; cmd_if.cmd_ack_err = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and times the inter-write gaps
  initial begin : monitor
    logic prev_v;
    logic [15:0] exp_w;
    int gap_seen;
    prev_v = 1'b0; gap_seen = 0;
    forever begin
      @(negedge clk); #1;
      if (cmd_if.cmd_valid && !prev_v && gap_seq != gap_seen) begin
        check("gap_len", cyc - done_cyc, 4);
        gap_seen = gap_seq;
      end
      prev_v = cmd_if.cmd_valid;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        accept_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got %h expected none", cmd_if.cmd_word);
        end else begin
          exp_w = exp_q.pop_front();
          check("cmd_word", cmd_if.cmd_word, exp_w);
        end
      end
    end
  end

  task automatic release_reset();
    int k;
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    while (!cmd_if.cmd_valid && k < 100) begin @(negedge clk); k++; end
    check("power_up_latency", k, 21);
  endtask

  task automatic wait_flag(input bit want_err, input int max_cyc, input string name);
    int k = 0;
    while (!(want_err ? o_error : o_done) && k < max_cyc) begin @(negedge clk); k++; end
    check(name, want_err ? o_error : o_done, 1);
  endtask

  task automatic wait_accepts(input int target, input int max_cyc);
    int k = 0;
    while (accept_cnt < target && k < max_cyc) begin @(negedge clk); #2; k++; end
    check("accept_count", accept_cnt, target);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin : stimulus
    int base, k;
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
    start = 1'b0; b_start = 1'b0;
    cmd_b.cmd_ready = 1'b1; cmd_b.cmd_done = 1'b0; cmd_b.cmd_ack_err = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_if.cmd_valid, 0);
    check("rst_word", cmd_if.cmd_word, 16'h0000);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_err_index", o_err_index, 0);
    check("rst_i2s", o_i2s_enable, 0);
    check("dev_addr", cmd_if.cmd_dev_addr, 7'h1A);

    // Plain bring-up, everything ACKed first time
    push_range(0, NREG - 1);
    release_reset();
    wait_flag(1'b0, 400, "s1_done");
    check("s1_queue_empty", exp_q.size(), 0);

    // Index 4 NACKed twice; stray i_start during a GAP
    nack_plan[4] = 2;
    push_range(0, 4); push_range(4, 4); push_range(4, NREG - 1);
    base = accept_cnt;
    pulse_start();
    wait_accepts(base + 3, 100);
    repeat (5) @(negedge clk);
    start = 1'b1;
    check("start_in_gap_busy", o_busy, 1);
    @(negedge clk); start = 1'b0;
    wait_flag(1'b0, 400, "s2_done");
    check("s2_no_error", o_error, 0);
    check("s2_queue_empty", exp_q.size(), 0);

    // Index 2 NACKed every time: 4 attempts then ERROR
    nack_plan[4] = 0; nack_plan[2] = 15;
    push_range(0, 2); push_range(2, 2); push_range(2, 2); push_range(2, 2);
    pulse_start();
    wait_flag(1'b1, 400, "s3_error");
    check("s3_err_index", o_err_index, 2);
    check("s3_done", o_done, 0);
    check("s3_i2s", o_i2s_enable, 0);
    check("s3_busy", o_busy, 0);
    check("s3_queue_empty", exp_q.size(), 0);
    nack_plan[2] = 0;
    push_range(0, NREG - 1);
    pulse_start();
    check("s3_restart_no_wait", cmd_if.cmd_valid, 1);
    check("s3_error_cleared", o_error, 0);
    wait_flag(1'b0, 400, "s3_restart_done");

    // Ready held low for the first command; stray done inside a GAP
    @(negedge clk); stall_req = 1'b1; stray_req = 1'b1;
    push_range(0, NREG - 1);
    pulse_start();
    wait_flag(1'b0, 400, "s4_done");
    check("s4_queue_empty", exp_q.size(), 0);

    // Async reset in WAIT_DONE of index 5
    push_range(0, 5);
    base = accept_cnt;
    pulse_start();
    wait_accepts(base + 6, 200);
    @(posedge clk); #2;
    check("s5_busy_before_rst", o_busy, 1);
    reset_n = 1'b0; epoch++;
    #1;
    check("s5_rst_valid", cmd_if.cmd_valid, 0);
    check("s5_rst_busy", o_busy, 0);
    check("s5_rst_done", o_done, 0);
    check("s5_rst_word", cmd_if.cmd_word, 16'h0000);
    check("s5_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    push_range(0, NREG - 1);
    release_reset();
    wait_flag(1'b0, 400, "s5_done");

    // AUTO_START=0 instance: idle until i_start
    check("b_no_cmd", b_valid_cnt, 0);
    check("b_idle_busy", b_busy, 0);
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    k = 1;
    while (!cmd_b.cmd_valid && k < 60) begin @(negedge clk); k++; end
    check("b_latency", k, 21);
    check("b_first_word", cmd_b.cmd_word, 16'h1E00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
